// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its CPU/peripheral requesters and the memory port.
// The slave modport is the arbiter's view; master is the view of the surrounding system.
interface mem_arbiter_if #(
  parameter int word_size = 32,
  parameter int num_per   = 3
);
  logic                           interrupt_disable;
  logic                           cpu_req;
  logic                           cpu_we;
  logic [word_size-1:0]           cpu_addr;
  logic [word_size-1:0]           cpu_wdata;
  logic [num_per-1:0]             per_req;
  logic [num_per-1:0]             per_we;
  logic [num_per*word_size-1:0]   per_addr;
  logic [num_per*word_size-1:0]   per_wdata;
  logic                           cpu_gnt;
  logic                           cpu_done;
  logic [num_per-1:0]             per_gnt;
  logic [num_per-1:0]             per_done;
  logic                           err;
  logic [word_size-1:0]           rdata;
  logic                           mem_en;
  logic                           mem_we;
  logic [word_size-1:0]           mem_addr;
  logic [word_size-1:0]           mem_wdata;
  logic [word_size-1:0]           mem_rdata;
  logic                           mem_ready;
  logic                           busy;

  modport slave (
    input  interrupt_disable, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           per_req, per_we, per_addr, per_wdata, mem_rdata, mem_ready,
    output cpu_gnt, cpu_done, per_gnt, per_done, err, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output interrupt_disable, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           per_req, per_we, per_addr, per_wdata, mem_rdata, mem_ready,
    input  cpu_gnt, cpu_done, per_gnt, per_done, err, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU priority, round-robin peripherals with a starvation guard,
// IDLE -> ACCESS -> COMPLETE transfer sequencing with a wait-state timeout. All outputs registered.
module mem_arbiter #(
  parameter int word_size      = 32,
  parameter int num_per        = 3,
  parameter int timeout_cycles = 15,
  parameter int cpu_burst_max  = 4
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int ptr_w    = (num_per > 1) ? $clog2(num_per) : 1;
  localparam int cnt_w    = $clog2(timeout_cycles + 1);
  localparam int streak_w = (cpu_burst_max > 0) ? $clog2(cpu_burst_max + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [ptr_w-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [ptr_w-1:0]       owner_idx_reg, owner_idx_next;
  logic [streak_w-1:0]    cpu_streak_reg, cpu_streak_next;
  logic [cnt_w-1:0]       wait_cnt_reg, wait_cnt_next;
  logic                   cpu_gnt_reg, cpu_gnt_next;
  logic                   cpu_done_reg, cpu_done_next;
  logic [num_per-1:0]     per_gnt_reg, per_gnt_next;
  logic [num_per-1:0]     per_done_reg, per_done_next;
  logic                   err_reg, err_next;
  logic [word_size-1:0]   rdata_reg, rdata_next;
  logic                   mem_en_reg, mem_en_next;
  logic                   mem_we_reg, mem_we_next;
  logic [word_size-1:0]   mem_addr_reg, mem_addr_next;
  logic [word_size-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                   busy_reg, busy_next;

  logic [word_size-1:0]   per_addr_arr  [num_per];
  logic [word_size-1:0]   per_wdata_arr [num_per];
  logic [ptr_w-1:0]       cand;
  logic [ptr_w-1:0]       per_win;
  logic                   per_found;
  logic                   per_pending;
  logic                   starve;
  logic                   finish;

  generate
    for (genvar gi = 0; gi < num_per; gi++) begin : g_unpack
      assign per_addr_arr[gi]  = bus.per_addr[gi*word_size +: word_size];
      assign per_wdata_arr[gi] = bus.per_wdata[gi*word_size +: word_size];
    end
  endgenerate

  // Round-robin search starting at rr_ptr; first asserted request wins.
  always_comb begin
    per_found = 1'b0;
    per_win   = '0;
    cand      = '0;
    for (int k = 0; k < num_per; k++) begin
      cand = ptr_w'((int'(rr_ptr_reg) + k) % num_per);
      if (!per_found && bus.per_req[cand]) begin
        per_found = 1'b1;
        per_win   = cand;
      end
    end
  end

  // While a fetch sequence is running the peripherals neither compete nor feed the guard.
  assign per_pending = per_found && !bus.interrupt_disable;
  assign starve      = per_pending && (cpu_streak_reg == streak_w'(cpu_burst_max));

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    owner_idx_next  = owner_idx_reg;
    cpu_streak_next = cpu_streak_reg;
    wait_cnt_next   = wait_cnt_reg;
    cpu_gnt_next    = cpu_gnt_reg;
    per_gnt_next    = per_gnt_reg;
    cpu_done_next   = 1'b0;
    per_done_next   = '0;
    err_next        = 1'b0;
    rdata_next      = rdata_reg;
    mem_en_next     = mem_en_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    busy_next       = busy_reg;
    finish          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.cpu_req && !starve) begin
          state_next      = ACCESS;
          cpu_gnt_next    = 1'b1;
          mem_en_next     = 1'b1;
          mem_we_next     = bus.cpu_we;
          mem_addr_next   = bus.cpu_addr;
          mem_wdata_next  = bus.cpu_wdata;
          wait_cnt_next   = '0;
          busy_next       = 1'b1;
          cpu_streak_next = per_pending ? cpu_streak_reg + streak_w'(1) : '0;
        end else if (per_pending) begin
          state_next            = ACCESS;
          per_gnt_next          = '0;
          per_gnt_next[per_win] = 1'b1;
          owner_idx_next        = per_win;
          mem_en_next           = 1'b1;
          mem_we_next           = bus.per_we[per_win];
          mem_addr_next         = per_addr_arr[per_win];
          mem_wdata_next        = per_wdata_arr[per_win];
          wait_cnt_next         = '0;
          busy_next             = 1'b1;
          cpu_streak_next       = '0;
        end
      end

      ACCESS: begin
        if (bus.mem_ready) begin
          finish = 1'b1;
          if (!mem_we_reg) begin
            rdata_next = bus.mem_rdata;
          end
        end else if (wait_cnt_reg == cnt_w'(timeout_cycles - 1)) begin
          finish   = 1'b1;
          err_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + cnt_w'(1);
        end

        if (finish) begin
          state_next    = COMPLETE;
          mem_en_next   = 1'b0;
          cpu_gnt_next  = 1'b0;
          per_gnt_next  = '0;
          cpu_done_next = cpu_gnt_reg;
          per_done_next = per_gnt_reg;
          wait_cnt_next = '0;
          if (|per_gnt_reg) begin
            rr_ptr_next = (owner_idx_reg == ptr_w'(num_per - 1)) ? '0
                                                                  : owner_idx_reg + ptr_w'(1);
          end
        end
      end

      COMPLETE: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      owner_idx_reg  <= '0;
      cpu_streak_reg <= '0;
      wait_cnt_reg   <= '0;
      cpu_gnt_reg    <= 1'b0;
      cpu_done_reg   <= 1'b0;
      per_gnt_reg    <= '0;
      per_done_reg   <= '0;
      err_reg        <= 1'b0;
      rdata_reg      <= '0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      owner_idx_reg  <= owner_idx_next;
      cpu_streak_reg <= cpu_streak_next;
      wait_cnt_reg   <= wait_cnt_next;
      cpu_gnt_reg    <= cpu_gnt_next;
      cpu_done_reg   <= cpu_done_next;
      per_gnt_reg    <= per_gnt_next;
      per_done_reg   <= per_done_next;
      err_reg        <= err_next;
      rdata_reg      <= rdata_next;
      mem_en_reg     <= mem_en_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      busy_reg       <= busy_next;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt_reg;
  assign bus.cpu_done  = cpu_done_reg;
  assign bus.per_gnt   = per_gnt_reg;
  assign bus.per_done  = per_done_reg;
  assign bus.err       = err_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios push expected grants/completions,
// a negedge monitor pops and compares them as the arbiter presents grant and done pulses.
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam int NP = 3;
  localparam logic [W-1:0] RD_XOR = 32'hC0DE_0000;

  typedef struct {
    logic [3:0]   gnt;
    logic [W-1:0] addr;
    logic         we;
    logic [W-1:0] wdata;
  } grant_t;

  typedef struct {
    logic [3:0]   done;
    logic         err;
    logic [W-1:0] rdata;
    int           acc;
  } done_t;

  logic clock = 1'b0;
  logic reset;

  mem_arbiter_if #(.word_size(W), .num_per(NP)) bus ();

  mem_arbiter #(
    .word_size(W), .num_per(NP), .timeout_cycles(15), .cpu_burst_max(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  grant_t       gq[$];
  done_t        dq[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_rdata = '0;
  int           mem_lat = 0;
  bit           fixed_en = 1'b0;
  logic [W-1:0] fixed_val = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] gvec();
    return {bus.cpu_gnt, bus.per_gnt};
  endfunction

  function automatic logic [127:0] outvec();
    return 128'({bus.cpu_gnt, bus.cpu_done, bus.per_gnt, bus.per_done, bus.err, bus.rdata,
                 bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy});
  endfunction

  // Expected read data is tracked in issue order: writes and timeouts leave it unchanged.
  task automatic push_xfer(input logic [3:0] g, input logic [W-1:0] addr, input logic we,
                           input logic [W-1:0] wd, input logic err, input logic [W-1:0] rd,
                           input int acc);
    grant_t gi;
    done_t  di;
    gi.gnt = g; gi.addr = addr; gi.we = we; gi.wdata = wd;
    gq.push_back(gi);
    if (!we && !err) exp_rdata = rd;
    di.done = g; di.err = err; di.rdata = exp_rdata; di.acc = acc;
    dq.push_back(di);
  endtask

  task automatic push_read(input logic [3:0] g, input logic [W-1:0] addr);
    push_xfer(g, addr, 1'b0, '0, 1'b0, addr ^ RD_XOR, 1);
  endtask

  task automatic wait_grant(input logic [3:0] want, input int budget, input string name);
    logic [3:0] prev;
    bit         hit;
    int         n;
    prev = gvec();
    hit  = 1'b0;
    n    = 0;
    while (!hit && n < budget) begin
      @(negedge clock);
      n++;
      if (gvec() == want && prev != want) hit = 1'b1;
      prev = gvec();
    end
    check({"wait_grant_", name}, 128'(hit), 128'(1));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((bus.busy || gq.size() != 0 || dq.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({"idle_", name}, 128'({bus.busy, gq.size() != 0, dq.size() != 0}), 128'(0));
  endtask

  // Memory model: ready after mem_lat ACCESS cycles (never when negative).
  initial begin
    int acc_cnt;
    acc_cnt       = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (bus.mem_en) begin
        bus.mem_ready = (mem_lat >= 0) && (acc_cnt >= mem_lat);
        bus.mem_rdata = fixed_en ? fixed_val : (bus.mem_addr ^ RD_XOR);
        acc_cnt++;
      end else begin
        acc_cnt       = 0;
        bus.mem_ready = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    grant_t g;
    done_t  d;
    logic   prev_g, prev_d, any_g, any_d;
    int     cyc, gcyc;
    prev_g = 1'b0; prev_d = 1'b0; cyc = 0; gcyc = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        prev_g = 1'b0;
        prev_d = 1'b0;
      end else begin
        any_g = bus.cpu_gnt | (|bus.per_gnt);
        any_d = bus.cpu_done | (|bus.per_done);
        if (any_g && !prev_g) begin
          check("gnt_onehot", 128'($countones(gvec())), 128'(1));
          if (gq.size() == 0) begin
            check("unexpected_grant", 128'(gvec()), 128'(0));
          end else begin
            g = gq.pop_front();
            $display("grant  gnt=%b addr=%h we=%b wdata=%h", gvec(), bus.mem_addr, bus.mem_we,
                     bus.mem_wdata);
            check("grant_vec", 128'(gvec()), 128'(g.gnt));
            check("grant_addr", 128'(bus.mem_addr), 128'(g.addr));
            check("grant_we", 128'(bus.mem_we), 128'(g.we));
            if (g.we) check("grant_wdata", 128'(bus.mem_wdata), 128'(g.wdata));
            check("grant_en_busy", 128'({bus.mem_en, bus.busy}), 128'(2'b11));
          end
          gcyc = cyc;
        end
        if (any_d) begin
          check("done_single_pulse", 128'(prev_d), 128'(0));
          if (dq.size() == 0) begin
            check("unexpected_done", 128'({bus.cpu_done, bus.per_done}), 128'(0));
          end else begin
            d = dq.pop_front();
            $display("done   done=%b err=%b rdata=%h access_cycles=%0d",
                     {bus.cpu_done, bus.per_done}, bus.err, bus.rdata, cyc - gcyc);
            check("done_vec", 128'({bus.cpu_done, bus.per_done}), 128'(d.done));
            check("done_err", 128'(bus.err), 128'(d.err));
            check("done_rdata", 128'(bus.rdata), 128'(d.rdata));
            check("done_access_cycles", 128'(cyc - gcyc), 128'(d.acc));
            check("done_gnt_cleared", 128'({any_g, bus.mem_en, bus.busy}), 128'(3'b001));
          end
        end
        if (bus.err && !any_d) check("err_without_done", 128'(bus.err), 128'(0));
        prev_g = any_g;
        prev_d = any_d;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    reset = 1'b0;
    bus.interrupt_disable = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.per_req = '0; bus.per_we = '0;
    bus.per_addr  = {32'h0000_0208, 32'h0000_0204, 32'h0000_0200};
    bus.per_wdata = {32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    #2;
    check("reset_outputs", outvec(), 128'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // CPU and all peripherals together: CPU first, then peripheral 0.
    push_read(4'b1000, 32'h0000_0100);
    push_read(4'b0001, 32'h0000_0200);
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_0100; bus.per_req = 3'b111;
    @(negedge clock);
    check("cpu_gnt_cycle1", 128'(gvec()), 128'(4'b1000));
    bus.cpu_req = 1'b0;
    @(negedge clock);
    check("cpu_done_cycle2", 128'(bus.cpu_done), 128'(1));
    wait_grant(4'b0001, 10, "p0_after_cpu");
    bus.per_req = 3'b000;
    wait_idle(20, "mixed");

    // Idle reset clears rdata and the round-robin pointer.
    reset = 1'b0;
    exp_rdata = '0;
    #1;
    check("reset_idle_outputs", outvec(), 128'(0));
    @(negedge clock);

    // Round-robin with all peripherals held; first arbitration on the first edge after release.
    push_read(4'b0001, 32'h0000_0200);
    push_xfer(4'b0010, 32'h0000_0204, 1'b1, 32'h1111_0001, 1'b0, '0, 1);
    push_read(4'b0100, 32'h0000_0208);
    push_read(4'b0001, 32'h0000_0200);
    reset = 1'b1;
    bus.per_we = 3'b010;
    bus.per_req = 3'b111;
    @(negedge clock);
    check("first_arb_after_reset", 128'(gvec()), 128'(4'b0001));
    wait_grant(4'b0010, 10, "rr_p1");
    wait_grant(4'b0100, 10, "rr_p2");
    wait_grant(4'b0001, 10, "rr_wrap_p0");
    bus.per_req = 3'b000;
    bus.per_we  = 3'b000;
    wait_idle(20, "rr");

    // Starvation guard: four CPU writes, then the waiting peripheral 1.
    for (int i = 0; i < 4; i++) push_xfer(4'b1000, 32'h0000_0300, 1'b1, 32'hCAFE_0000, 1'b0, '0, 1);
    push_read(4'b0010, 32'h0000_0204);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0000_0300;
    bus.cpu_wdata = 32'hCAFE_0000; bus.per_req = 3'b010;
    wait_grant(4'b0010, 40, "starve_p1");
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.per_req = 3'b000;
    wait_idle(20, "starve");

    // Fetch sequence masks peripherals: CPU only.
    for (int i = 0; i < 6; i++) push_read(4'b1000, 32'h0000_0400);
    bus.interrupt_disable = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_0400; bus.per_req = 3'b010;
    for (int i = 0; i < 6; i++) wait_grant(4'b1000, 10, "masked_cpu");
    bus.cpu_req = 1'b0;
    wait_idle(20, "masked");
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (|bus.per_gnt) seen = 1'b1;
    end
    check("masked_no_per_grant", 128'(seen), 128'(0));
    bus.per_req = 3'b000;
    bus.interrupt_disable = 1'b0;

    // Slow read: ready after three wait cycles.
    mem_lat = 3; fixed_en = 1'b1; fixed_val = 32'hDEAD_BEEF;
    push_xfer(4'b1000, 32'h0000_0010, 1'b0, '0, 1'b0, 32'hDEAD_BEEF, 4);
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_0010;
    wait_grant(4'b1000, 10, "slow_read");
    bus.cpu_req = 1'b0;
    wait_idle(20, "slow_read");
    fixed_en = 1'b0;

    // Timeout: memory never ready, rdata keeps DEADBEEF.
    mem_lat = -1;
    push_xfer(4'b1000, 32'h0000_0020, 1'b0, '0, 1'b1, '0, 15);
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_0020;
    wait_grant(4'b1000, 10, "timeout");
    bus.cpu_req = 1'b0;
    wait_idle(40, "timeout");

    // interrupt_disable rising mid-transfer does not preempt peripheral 0.
    mem_lat = 2;
    push_xfer(4'b0001, 32'h0000_0200, 1'b0, '0, 1'b0, 32'h0000_0200 ^ RD_XOR, 3);
    bus.per_req = 3'b001;
    wait_grant(4'b0001, 10, "p0_no_preempt");
    bus.per_req = 3'b000;
    bus.interrupt_disable = 1'b1;
    wait_idle(20, "no_preempt");
    bus.interrupt_disable = 1'b0;

    // Asynchronous reset in the second ACCESS cycle of a peripheral 1 transfer.
    mem_lat = -1;
    begin
      grant_t ga;
      ga.gnt = 4'b0010; ga.addr = 32'h0000_0204; ga.we = 1'b0; ga.wdata = '0;
      gq.push_back(ga);
    end
    bus.per_req = 3'b010;
    wait_grant(4'b0010, 10, "p1_abort");
    bus.per_req = 3'b000;
    @(negedge clock);
    #2;
    reset = 1'b0;
    exp_rdata = '0;
    #1;
    check("async_reset_outputs", outvec(), 128'(0));
    @(negedge clock);
    @(negedge clock);
    check("reset_hold_outputs", outvec(), 128'(0));
    mem_lat = 0;
    push_read(4'b0001, 32'h0000_0200);
    reset = 1'b1;
    bus.per_req = 3'b111;
    @(negedge clock);
    check("rr_ptr_reset_grant", 128'(gvec()), 128'(4'b0001));
    bus.per_req = 3'b000;
    wait_idle(20, "after_reset");
    push_read(4'b0100, 32'h0000_0208);
    bus.per_req = 3'b100;
    wait_grant(4'b0100, 10, "p2_alone");
    bus.per_req = 3'b000;
    wait_idle(20, "p2_alone");

    check("scoreboard_drained", 128'({gq.size(), dq.size()}), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: word_size, 32, data/address width; num_per, 3, peripheral requester count; timeout_cycles, 15, max ACCESS cycles before abort; cpu_burst_max, 4, consecutive CPU grants allowed while a peripheral waits.
REQ-002 clock  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-low; reset==0 forces reset state immediately, independent of clock.
REQ-004 interrupt_disable  in  1  high while the control unit is in a fetch sequence; masks peripheral arbitration.
REQ-005 cpu_req, cpu_we  in  1 each  CPU access request and write-enable.
REQ-006 cpu_addr, cpu_wdata  in  word_size each  CPU address and write data.
REQ-007 per_req, per_we  in  num_per each  peripheral requests and write-enables, bit i = peripheral i.
REQ-008 per_addr, per_wdata  in  num_per*word_size each  packed; peripheral i occupies bits [i*word_size +: word_size].
REQ-009 cpu_gnt, cpu_done  out  1 each  CPU grant and completion pulse.
REQ-010 per_gnt, per_done  out  num_per each  one-hot peripheral grant and completion pulse.
REQ-011 err  out  1  timeout pulse, coincident with the done pulse of the aborted transfer.
REQ-012 rdata  out  word_size  read data, valid while done is high and held until the next read completes.
REQ-013 mem_en, mem_we  out  1 each  memory strobe and write-enable.
REQ-014 mem_addr, mem_wdata  out  word_size each  memory address and write data.
REQ-015 mem_rdata  in  word_size  memory read data; mem_ready  in  1  memory completion.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM SHALL have states IDLE, ACCESS and COMPLETE; all outputs SHALL be registered.
REQ-018 IDLE: arbitrate on sampled requests. If any request qualifies, go to ACCESS next edge with the winner's gnt bit set, and latch the winner's addr/wdata/we onto mem_addr, mem_wdata and mem_we. If none qualifies, stay in IDLE.
REQ-019 Priority: cpu_req beats any peripheral, except as REQ-021 allows.
REQ-020 Peripherals: round-robin from pointer rr_ptr (reset 0). Search rr_ptr, rr_ptr+1, ... mod num_per; the first asserted per_req wins.
REQ-021 Starvation guard: cpu_streak counts consecutive CPU grants made while any per_req was high. When cpu_streak==cpu_burst_max and interrupt_disable==0, a pending peripheral wins over the CPU. cpu_streak clears on any peripheral grant.
REQ-022 interrupt_disable==1: peripherals excluded from arbitration; CPU-only arbitration; REQ-021 is suppressed.
REQ-023 ACCESS: mem_en=1. Wait counter starts at 0 and increments each cycle. On the edge where mem_ready==1: latch mem_rdata into rdata (reads only) and go to COMPLETE.
REQ-024 Timeout: if the counter reaches timeout_cycles with mem_ready low, go to COMPLETE with err=1; rdata is left unchanged.
REQ-025 COMPLETE: one cycle. Outputs: mem_en=0; the winner's done=1; gnt cleared; rr_ptr = (granted peripheral index + 1) mod num_per, for peripheral grants only. Then go to IDLE.
REQ-026 Minimum transfer: IDLE -> ACCESS -> COMPLETE is 3 cycles from request sample to done when mem_ready is high in the first ACCESS cycle. The next grant is possible no earlier than the cycle after COMPLETE.
REQ-027 Requester deasserting req during ACCESS does not abort the transfer; done is still pulsed.
REQ-028 interrupt_disable rising during ACCESS does not preempt an in-flight peripheral transfer.
REQ-029 At most one gnt bit (cpu_gnt or per_gnt) SHALL be high in any cycle; done and err SHALL be single-cycle pulses.

Reset
REQ-030 reset==0 SHALL force state=IDLE, rr_ptr=0, cpu_streak=0 and the wait counter to 0. All outputs go to 0, including rdata, mem_addr and mem_wdata. This applies mid-transfer and with no done pulse generated.
REQ-031 After reset is released, the first arbitration SHALL occur on the first posedge with reset==1.

Verification
REQ-032 cpu_req=1 and per_req=3'b111 asserted together, interrupt_disable=0, mem_ready=1 -> cpu_gnt in cycle 1, cpu_done in cycle 2, then per_gnt=3'b001 follows.
REQ-033 per_req=3'b111 held, cpu_req=0 -> grant order 001,010,100,001; rr_ptr wraps 2->0.
REQ-034 cpu_req held high, per_req[1]=1, interrupt_disable=0 -> four CPU grants, then per_gnt=3'b010; with interrupt_disable=1 -> CPU only, no peripheral grant.
REQ-035 CPU read at cpu_addr=32'h10, mem_ready delayed 3 ACCESS cycles with mem_rdata=32'hDEADBEEF -> rdata=32'hDEADBEEF when cpu_done=1; err=0.
REQ-036 mem_ready tied 0 -> after timeout_cycles (15) ACCESS cycles, done and err pulse together for one cycle; rdata is unchanged.
REQ-037 reset pulled low in the 2nd ACCESS cycle -> all outputs 0 asynchronously; no done pulse; after release, per_req=3'b100 alone is granted with rr_ptr back at 0.
